// File: rtl/log_stream_sink.sv
// log_stream_sink
// Avalon-ST video sink for a 24-bit, one-pixel-per-beat stream. It decodes
// control packets into frame geometry and walks data packets pixel by pixel.
// It reports per-frame statistics and raises sticky framing/geometry errors.
//
// Ports
//   clock, reset_n             : rising-edge clock, async active-low reset
//   din_valid/data/sop/eop     : sink beat; every valid beat is taken
//   din_empty                  : unused (one pixel per beat)
//   din_ready                  : registered ~hold, ready latency 1
//   hold                       : backpressure request
//   clear_err                  : clears the sticky error flags
//   frame_width/frame_height   : last committed control-packet geometry
//   ctrl_valid                 : pulse when a control packet commits
//   frame_done                 : pulse at the end of each data packet
//   frame_cnt                  : completed data packets (wraps)
//   pix_count/front_count      : pixels / FRONT_COLOR pixels of last frame
//   framing_err, ctrl_err, size_err, overrun_err : sticky flags
module log_stream_sink #(
  parameter logic [23:0] FRONT_COLOR = 24'hffffff,
  parameter int unsigned CNT_W       = 24
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             din_valid,
  input  logic [23:0]      din_data,
  input  logic             din_sop,
  input  logic             din_eop,
  input  logic [1:0]       din_empty,
  output logic             din_ready,
  input  logic             hold,
  input  logic             clear_err,
  output logic [15:0]      frame_width,
  output logic [15:0]      frame_height,
  output logic             ctrl_valid,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic [CNT_W-1:0] pix_count,
  output logic [CNT_W-1:0] front_count,
  output logic             framing_err,
  output logic             ctrl_err,
  output logic             size_err,
  output logic             overrun_err
);

  typedef enum logic [1:0] {S_IDLE, S_CTRL, S_DATA, S_SKIP} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             r_state, w_state_nx;
  logic               r_ready, r_ready_d;
  logic [1:0]         r_k;
  logic [15:0]        r_w_acc, r_h_acc, w_w_nx, w_h_nx;
  logic [15:0]        r_x, r_y;
  logic [CNT_W-1:0]   r_pix_run, r_front_run, w_pix_nx, w_front_nx;
  logic [15:0]        r_frame_width, r_frame_height, r_frame_cnt;
  logic [CNT_W-1:0]   r_pix_count, r_front_count;
  logic               r_ctrl_valid, r_frame_done;
  logic               r_framing_err, r_ctrl_err, r_size_err, r_overrun_err;

  logic               w_sop_beat, w_body, w_ctrl_beat, w_data_beat;
  logic [3:0]         w_type;
  logic               w_x_last, w_y_last;
  logic               w_ctrl_commit, w_set_framing, w_set_ctrl, w_set_size, w_set_overrun;
  logic               w_unused_empty;

  assign w_unused_empty = ^din_empty;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  // Next state: a sop beat re-decodes the packet type from any state
  always_comb begin
    w_state_nx = r_state;
    if (din_valid) begin
      if (din_sop) begin
        if (din_eop)                   w_state_nx = S_IDLE;
        else if (din_data[3:0] == 4'hF) w_state_nx = S_CTRL;
        else if (din_data[3:0] == 4'h0) w_state_nx = S_DATA;
        else                           w_state_nx = S_SKIP;
      end else if (r_state != S_IDLE && din_eop) begin
        w_state_nx = S_IDLE;
      end
    end
  end

  // Beat decode, control-field assembly and error detection
  always_comb begin
    w_sop_beat  = din_valid & din_sop;
    w_body      = din_valid & ~din_sop;
    w_type      = din_data[3:0];
    w_ctrl_beat = w_body && (r_state == S_CTRL);
    w_data_beat = w_body && (r_state == S_DATA);

    w_w_nx = r_w_acc;
    w_h_nx = r_h_acc;
    if (w_ctrl_beat) begin
      case (r_k)
        2'd0: begin
          w_w_nx[7:4]   = din_data[19:16];
          w_w_nx[11:8]  = din_data[11:8];
          w_w_nx[15:12] = din_data[3:0];
        end
        2'd1: begin
          w_h_nx[11:8]  = din_data[19:16];
          w_h_nx[15:12] = din_data[11:8];
          w_w_nx[3:0]   = din_data[3:0];
        end
        2'd2: begin
          w_h_nx[3:0]   = din_data[11:8];
          w_h_nx[7:4]   = din_data[3:0];
        end
        default: ;
      endcase
    end

    w_pix_nx   = (&r_pix_run) ? r_pix_run : r_pix_run + CNT_ONE;
    w_front_nx = r_front_run;
    if (din_data == FRONT_COLOR && !(&r_front_run)) w_front_nx = r_front_run + CNT_ONE;

    w_x_last = (r_x == r_frame_width - 16'd1);
    w_y_last = (r_y == r_frame_height - 16'd1);

    w_ctrl_commit = w_ctrl_beat & din_eop & (r_k >= 2'd2);
    w_set_framing = (w_sop_beat && r_state != S_IDLE) || (w_body && r_state == S_IDLE);
    w_set_ctrl    = (w_ctrl_beat & din_eop & (r_k < 2'd2)) ||
                    (w_sop_beat & din_eop & (w_type == 4'hF));
    w_set_size    = (w_data_beat & din_eop &
                     (~(w_x_last & w_y_last) | (r_frame_width == 16'd0) | (r_frame_height == 16'd0))) ||
                    (w_sop_beat & din_eop & (w_type == 4'h0));
    w_set_overrun = din_valid & ~r_ready_d;
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ready        <= 1'b0;
      r_ready_d      <= 1'b0;
      r_k            <= '0;
      r_w_acc        <= '0;
      r_h_acc        <= '0;
      r_x            <= '0;
      r_y            <= '0;
      r_pix_run      <= '0;
      r_front_run    <= '0;
      r_frame_width  <= '0;
      r_frame_height <= '0;
      r_frame_cnt    <= '0;
      r_pix_count    <= '0;
      r_front_count  <= '0;
      r_ctrl_valid   <= 1'b0;
      r_frame_done   <= 1'b0;
      r_framing_err  <= 1'b0;
      r_ctrl_err     <= 1'b0;
      r_size_err     <= 1'b0;
      r_overrun_err  <= 1'b0;
    end else begin
      r_ready   <= ~hold;
      r_ready_d <= r_ready;

      if (w_sop_beat && w_type == 4'hF) begin
        r_k     <= '0;
        r_w_acc <= '0;
        r_h_acc <= '0;
      end else if (w_ctrl_beat) begin
        r_w_acc <= w_w_nx;
        r_h_acc <= w_h_nx;
        if (r_k != 2'd3) r_k <= r_k + 2'd1;
      end

      if (w_sop_beat && w_type == 4'h0) begin
        r_x         <= '0;
        r_y         <= '0;
        r_pix_run   <= '0;
        r_front_run <= '0;
      end else if (w_data_beat) begin
        r_pix_run   <= w_pix_nx;
        r_front_run <= w_front_nx;
        if (w_x_last) begin
          r_x <= '0;
          r_y <= r_y + 16'd1;
        end else begin
          r_x <= r_x + 16'd1;
        end
      end

      r_ctrl_valid <= w_ctrl_commit;
      if (w_ctrl_commit) begin
        r_frame_width  <= w_w_nx;
        r_frame_height <= w_h_nx;
      end

      r_frame_done <= w_data_beat & din_eop;
      if (w_data_beat && din_eop) begin
        r_frame_cnt   <= r_frame_cnt + 16'd1;
        r_pix_count   <= w_pix_nx;
        r_front_count <= w_front_nx;
      end

      // A detection in the same cycle as clear_err wins
      r_framing_err <= (r_framing_err & ~clear_err) | w_set_framing;
      r_ctrl_err    <= (r_ctrl_err    & ~clear_err) | w_set_ctrl;
      r_size_err    <= (r_size_err    & ~clear_err) | w_set_size;
      r_overrun_err <= (r_overrun_err & ~clear_err) | w_set_overrun;
    end
  end

  assign din_ready    = r_ready;
  assign frame_width  = r_frame_width;
  assign frame_height = r_frame_height;
  assign ctrl_valid   = r_ctrl_valid;
  assign frame_done   = r_frame_done;
  assign frame_cnt    = r_frame_cnt;
  assign pix_count    = r_pix_count;
  assign front_count  = r_front_count;
  assign framing_err  = r_framing_err;
  assign ctrl_err     = r_ctrl_err;
  assign size_err     = r_size_err;
  assign overrun_err  = r_overrun_err;

endmodule

// File: tb/tb_log_stream_sink.sv
`timescale 1ns/1ps
module tb_log_stream_sink;

  localparam logic [23:0] FRONT = 24'hffffff;
  localparam logic [23:0] OTHER = 24'h123456;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        din_valid = 1'b0;
  logic [23:0] din_data = '0;
  logic        din_sop = 1'b0;
  logic        din_eop = 1'b0;
  logic [1:0]  din_empty = 2'b11;
  logic        din_ready;
  logic        hold = 1'b0;
  logic        clear_err = 1'b0;
  logic [15:0] frame_width, frame_height, frame_cnt;
  logic        ctrl_valid, frame_done;
  logic [23:0] pix_count, front_count;
  logic        framing_err, ctrl_err, size_err, overrun_err;

  log_stream_sink #(.FRONT_COLOR(24'hffffff), .CNT_W(24)) dut (
    .clock(clock), .reset_n(reset_n),
    .din_valid(din_valid), .din_data(din_data), .din_sop(din_sop),
    .din_eop(din_eop), .din_empty(din_empty), .din_ready(din_ready),
    .hold(hold), .clear_err(clear_err),
    .frame_width(frame_width), .frame_height(frame_height),
    .ctrl_valid(ctrl_valid), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .pix_count(pix_count), .front_count(front_count),
    .framing_err(framing_err), .ctrl_err(ctrl_err),
    .size_err(size_err), .overrun_err(overrun_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_frame;
    int unsigned a;  // width  | pix_count
    int unsigned b;  // height | front_count
    int unsigned c;  // unused | frame_cnt
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every output pulse consumes one expected entry
  always @(negedge clock) begin
    if (reset_n) begin
      if (ctrl_valid) begin
        if (exp_q.size() == 0) chk("unexpected ctrl_valid", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("ctrl pulse kind", 0, mon_e.is_frame);
          chk("ctrl width", frame_width, mon_e.a);
          chk("ctrl height", frame_height, mon_e.b);
        end
      end
      if (frame_done) begin
        if (exp_q.size() == 0) chk("unexpected frame_done", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("frame pulse kind", 1, mon_e.is_frame);
          chk("pix_count", pix_count, mon_e.a);
          chk("front_count", front_count, mon_e.b);
          chk("frame_cnt", frame_cnt, mon_e.c);
        end
      end
    end
  end

  task automatic push_ctrl(input int unsigned w, input int unsigned h);
    exp_t e;
    e.is_frame = 0; e.a = w; e.b = h; e.c = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input int unsigned p, input int unsigned f, input int unsigned c);
    exp_t e;
    e.is_frame = 1; e.a = p; e.b = f; e.c = c;
    exp_q.push_back(e);
  endtask

  // Caller sits at posedge+1; returns at posedge+1 after the beat is taken
  task automatic beat(input logic [23:0] d, input logic s, input logic e);
    din_valid = 1'b1; din_data = d; din_sop = s; din_eop = e;
    @(posedge clock); #1;
    din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_ctrl(input logic [23:0] b0, input logic [23:0] b1, input logic [23:0] b2);
    beat(24'h00000F, 1'b1, 1'b0);
    beat(b0, 1'b0, 1'b0);
    beat(b1, 1'b0, 1'b0);
    beat(b2, 1'b0, 1'b1);
  endtask

  task automatic send_pixels(input int n, input int nfront, input bit last_eop);
    for (int i = 0; i < n; i++)
      beat((i < nfront) ? FRONT : OTHER, 1'b0, last_eop && (i == n - 1));
  endtask

  task automatic send_frame(input int n, input int nfront);
    beat(24'h000000, 1'b1, 1'b0);
    send_pixels(n, nfront, 1'b1);
  endtask

  task automatic clr;
    clear_err = 1'b1;
    idle(1);
    clear_err = 1'b0;
  endtask

  function automatic logic [3:0] errs();
    return {framing_err, ctrl_err, size_err, overrun_err};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    idle(2);
    chk("rst ready/pulses/errs", {din_ready, ctrl_valid, frame_done, errs()}, 0);
    chk("rst geometry", {frame_width, frame_height}, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    chk("rst counts", {pix_count, front_count}, 0);
    reset_n = 1'b1;
    idle(1);
    chk("ready after reset", din_ready, 1);
    idle(1);

    // 1024x114 control packet
    push_ctrl(1024, 114);
    send_ctrl(24'h000400, 24'h000000, 24'h000207);
    chk("width 1024", frame_width, 1024);
    chk("height 114", frame_height, 114);

    // 1024x20 frame with 5000 front pixels, back-to-back after control eop
    push_ctrl(1024, 20);
    send_ctrl(24'h000400, 24'h000000, 24'h000401);
    push_frame(20480, 5000, 1);
    send_frame(20480, 5000);
    chk("errs after clean frame", errs(), 4'b0000);

    // Short control packet: eop on k=1
    beat(24'h00000F, 1'b1, 1'b0);
    beat(24'h000000, 1'b0, 1'b0);
    beat(24'h000004, 1'b0, 1'b1);
    chk("short ctrl errs", errs(), 4'b0100);
    chk("short ctrl keeps geometry", {frame_width, frame_height}, {16'd1024, 16'd20});
    clr();
    chk("ctrl_err cleared", errs(), 4'b0000);

    // W=4 H=2; 7-pixel frame is short, 8-pixel frame does not clear the flag
    push_ctrl(4, 2);
    send_ctrl(24'h000000, 24'h000004, 24'h000200);
    push_frame(7, 2, 2);
    send_frame(7, 2);
    chk("7-pixel size_err", errs(), 4'b0010);
    push_frame(8, 3, 3);
    send_frame(8, 3);
    chk("size_err sticky", errs(), 4'b0010);
    clr();
    chk("size_err cleared", errs(), 4'b0000);

    // Type 5 packet skipped silently, then a valid frame
    beat(24'h000005, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) beat(FRONT, 1'b0, i == 8);
    chk("skip errs", errs(), 4'b0000);
    chk("skip frame_cnt", frame_cnt, 3);
    push_frame(8, 0, 4);
    send_frame(8, 0);
    chk("errs after skip+frame", errs(), 4'b0000);

    // Framing: stray body beat in IDLE
    beat(24'h000000, 1'b0, 1'b0);
    chk("stray beat framing", errs(), 4'b1000);
    clr();
    // Abandoned data packet restarted by a new sop
    beat(24'h000000, 1'b1, 1'b0);
    send_pixels(3, 3, 1'b0);
    push_frame(8, 2, 5);
    send_frame(8, 2);
    chk("abandoned packet framing", errs(), 4'b1000);
    clr();
    // Data sop with eop
    beat(24'h000000, 1'b1, 1'b1);
    chk("sop+eop data size_err", errs(), 4'b0010);
    clr();

    // Backpressure: first beat after ready falls is legal, second overruns
    hold = 1'b1;
    idle(1);
    chk("ready low under hold", din_ready, 0);
    beat(24'h000000, 1'b1, 1'b0);
    chk("legal beat no overrun", errs(), 4'b0000);
    beat(FRONT, 1'b0, 1'b0);
    chk("overrun on second beat", errs(), 4'b0001);
    hold = 1'b0;
    idle(2);
    push_frame(8, 1, 6);
    send_pixels(7, 0, 1'b1);
    chk("overrun sticky", errs(), 4'b0001);
    clr();

    // Reset mid-data-packet
    beat(24'h000000, 1'b1, 1'b0);
    send_pixels(3, 1, 1'b0);
    reset_n = 1'b0;
    #2;
    chk("mid rst flags", {din_ready, ctrl_valid, frame_done, errs()}, 0);
    chk("mid rst geometry", {frame_width, frame_height}, 0);
    chk("mid rst counts", {frame_cnt, pix_count, front_count}, 0);
    idle(2);
    reset_n = 1'b1;
    idle(2);
    push_ctrl(4, 2);
    send_ctrl(24'h000000, 24'h000004, 24'h000200);
    push_frame(8, 4, 1);
    send_frame(8, 4);
    chk("post-reset frame_cnt", frame_cnt, 1);
    chk("post-reset errs", errs(), 4'b0000);

    idle(3);
    chk("pending expected pulses", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/log_stream_sink.md
# log_stream_sink

Avalon-ST video sink that receives the 24-bit, single-pixel-per-beat stream produced by the logo/video sources in this design. It decodes the 3-beat control packet into frame width and height, then walks each data packet pixel by pixel. It checks the packet framing and frame geometry, and reports per-frame statistics. It sits at the end of a source under test, or behind a tap point, as a hardware checker and status block for the framebuffer pipeline.

## Interface
- FRONT_COLOR, 24'hffffff: pixel value counted into `front_count`.
- CNT_W, 24: width of the pixel counters `front_count` and `pix_count`.
- clock  in  1  sole clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- din_valid  in  1  beat valid.
- din_data  in  24  beat data.
- din_sop  in  1  start of packet.
- din_eop  in  1  end of packet.
- din_empty  in  2  ignored.
- din_ready  out  1  sink ready. Ready latency is 1.
- hold  in  1  request backpressure.
- clear_err  in  1  clears the sticky error flags.
- frame_width  out  16  last committed width.
- frame_height  out  16  last committed height.
- ctrl_valid  out  1  one-cycle pulse when a control packet is committed.
- frame_done  out  1  one-cycle pulse at the end of a data packet.
- frame_cnt  out  16  number of completed data packets. Wraps.
- pix_count  out  CNT_W  pixels in the last data packet.
- front_count  out  CNT_W  pixels equal to FRONT_COLOR in the last data packet.
- framing_err, ctrl_err, size_err, overrun_err  out  1 each  sticky error flags.

## Operation
- Accept rule: a beat is taken in any cycle where `din_valid`=1.
  - `ready_d` is `din_ready` delayed by one cycle.
  - If `din_valid`=1 while `ready_d`=0, the beat is still processed and `overrun_err` is set.
- `din_ready` is registered: `din_ready <= ~hold`.
- States: IDLE, CTRL, DATA, SKIP.
- Packet type is `din_data[3:0]` on the sop beat:
  - 4'hF → CTRL.
  - 4'h0 → DATA.
  - Any other value → SKIP.
  - The type decision applies from any state.
- A sop beat in CTRL, DATA or SKIP sets `framing_err`. The current packet is abandoned with no commit and no `frame_done`. The new packet is then decoded normally.
- A non-sop beat in IDLE is discarded and sets `framing_err`.
- A sop beat that also has eop=1 returns to IDLE. For a CTRL or DATA type it sets the corresponding short-packet error: `ctrl_err` or `size_err`.
- CTRL: beat index k counts 0..2 after the header.
  - Beat 0 gives W[7:4]=d[19:16], W[11:8]=d[11:8], W[15:12]=d[3:0].
  - Beat 1 gives H[11:8]=d[19:16], H[15:12]=d[11:8], W[3:0]=d[3:0].
  - Beat 2 gives H[3:0]=d[11:8], H[7:4]=d[3:0].
  - Beats after index 2 are ignored.
  - On eop with k≥2: commit W and H to `frame_width` and `frame_height`, pulse `ctrl_valid`, go to IDLE.
  - On eop with k<2: set `ctrl_err`, make no commit, go to IDLE.
- DATA: x and y counters are 16 bits.
  - x increments per pixel. When x = `frame_width`−1, x wraps to 0 and y increments.
  - `pix_run` counts every pixel. `front_run` counts pixels equal to FRONT_COLOR. Both saturate at all-ones.
  - On the eop pixel: latch `pix_count` and `front_count`, pulse `frame_done`, increment `frame_cnt`, go to IDLE.
  - At that eop pixel, `size_err` is set unless x = W−1 and y = H−1.
  - `size_err` is also set if W=0 or H=0.
  - All run counters and x/y are cleared on every data sop.
- SKIP: discard beats until eop, then go to IDLE. No flags are raised.
- Error flags: sticky until `clear_err`=1. If a new error is detected in the same cycle as `clear_err`, the flag is set.

## Timing
- Reset value of every output is 0, including `din_ready` and `frame_width`/`frame_height`.
- `din_ready` rises on the first clock edge after reset release, provided `hold`=0.
- `ctrl_valid`, `frame_width` and `frame_height` update on the clock edge that accepts the control eop beat, so they are visible in the following cycle.
- `frame_done`, `frame_cnt`, `pix_count` and `front_count` update on the edge that accepts the data eop beat.
- Error flags set on the edge that accepts the offending beat.
- `hold` affects `din_ready` with 1 cycle of latency. The beat arriving in the cycle after `din_ready` falls is legal.
- Back-to-back packets are supported: a sop beat may directly follow an eop beat.
- Reset mid-packet returns to IDLE with all outputs at 0.

## Test plan
- Control packet 00000F, then beats 00_0_0_4_00 style encoding for W=1024, H=114, followed by a 1024×114 data packet with 5000 pixels = FRONT_COLOR → `frame_width`=1024, `frame_height`=114, one `ctrl_valid` pulse, `pix_count`=116736, `front_count`=5000, `frame_cnt`=1, all error flags 0.
- Control packet with header plus 2 beats (eop on k=1) → `ctrl_err`=1, `frame_width` and `frame_height` unchanged, no `ctrl_valid`.
- With W=4, H=2, a data packet of 7 pixels → `size_err`=1, `pix_count`=7, `frame_done` pulses. A following 8-pixel frame does not clear `size_err`. Pulsing `clear_err` clears it.
- Packet of type 4'h5 with 10 beats, then a valid frame → no flags set, `frame_cnt` increments only for the valid frame.
- `hold` asserted; source sends one beat the cycle after `din_ready` falls, then a second beat → first beat accepted cleanly, `overrun_err`=1 only on the second beat.
- `reset_n` low mid-data-packet, then a full control+data sequence → all outputs 0 during reset, clean frame afterwards, `frame_cnt`=1.
